// File: rtl/neuron_potential_array.sv
// Leaky integrate-and-fire potential array: accumulates weighted input beats per
// neuron during a timestep, then sequentially applies leak, threshold and reset.
module neuron_potential_array #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DATA_W-1:0]      v_threshold,
  input  logic [DATA_W-1:0]      v_reset,
  input  logic [4:0]             decay_shift,
  input  logic [1:0]             mode,
  input  logic                   ts_start,
  input  logic                   ts_end,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [IDX_W-1:0]       w_idx,
  input  logic [DATA_W-1:0]      w_data,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   done,
  output logic                   busy,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]      rd_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W:0]   LP_NUM  = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [DATA_W-1:0] LP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] LP_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic signed [DATA_W-1:0] r_v   [NUM_NEURONS];
  logic signed [DATA_W-1:0] r_acc [NUM_NEURONS];
  logic signed [DATA_W-1:0] r_thr;
  logic signed [DATA_W-1:0] r_vres;
  logic [4:0]               r_shift;
  logic [1:0]               r_mode;
  logic [NUM_NEURONS-1:0]   r_spike;

  logic                     w_beat;
  logic                     w_idx_ok;
  logic signed [DATA_W-1:0] w_acc_sel;
  logic signed [DATA_W-1:0] w_acc_new;
  logic signed [DATA_W-1:0] w_v_cur;
  logic signed [DATA_W-1:0] w_acc_cur;
  logic signed [DATA_W-1:0] w_decayed;
  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_sub;
  logic                     w_spike;
  logic signed [DATA_W-1:0] w_v_new;

  // Operands are sign-extended by one bit; a mismatch of the top two bits means overflow.
  function automatic logic signed [DATA_W-1:0] f_sat(input logic [DATA_W:0] x);
    if (x[DATA_W] != x[DATA_W-1]) return x[DATA_W] ? LP_MIN : LP_MAX;
    else return x[DATA_W-1:0];
  endfunction

  assign w_beat    = w_valid && (r_state == S_ACCUM);
  assign w_idx_ok  = ({1'b0, w_idx} < LP_NUM);
  assign w_acc_sel = w_idx_ok ? r_acc[w_idx] : '0;
  assign w_acc_new = f_sat({w_acc_sel[DATA_W-1], w_acc_sel} + {w_data[DATA_W-1], w_data});

  assign w_v_cur   = r_v[r_idx];
  assign w_acc_cur = r_acc[r_idx];
  // A zero shift would otherwise subtract the whole potential.
  assign w_decayed = (r_shift == '0) ? w_v_cur : (w_v_cur - (w_v_cur >>> r_shift));
  assign w_sum     = f_sat({w_decayed[DATA_W-1], w_decayed} + {w_acc_cur[DATA_W-1], w_acc_cur});
  assign w_spike   = (w_sum >= r_thr);
  assign w_sub     = f_sat({w_sum[DATA_W-1], w_sum} - {r_thr[DATA_W-1], r_thr});

  always_comb begin
    w_v_new = w_sum;
    case (r_mode)
      2'd1:    w_v_new = w_spike ? r_vres : w_sum;
      2'd2:    w_v_new = w_sum;
      default: w_v_new = w_spike ? w_sub : w_sum;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_thr   <= '0;
      r_vres  <= '0;
      r_shift <= '0;
      r_mode  <= '0;
      r_spike <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ts_start) begin
            r_thr   <= v_threshold;
            r_vres  <= v_reset;
            r_shift <= decay_shift;
            r_mode  <= mode;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) r_acc[i] <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_beat && w_idx_ok) r_acc[w_idx] <= w_acc_new;
          if (ts_end) begin
            r_idx   <= '0;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_v[r_idx]     <= w_v_new;
          r_spike[r_idx] <= w_spike;
          if (r_idx == LP_LAST) r_state <= S_DONE;
          else r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ready   = (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign spike_out = r_spike;
  assign rd_data   = ({1'b0, rd_idx} < LP_NUM) ? r_v[rd_idx] : '0;

endmodule

// File: tb/tb_neuron_potential_array.sv
// Directed bench for neuron_potential_array: a table of chained timesteps with
// hand-computed potentials, plus handshake and mid-update reset sequences.
module tb_neuron_potential_array;

  localparam int NN = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          CLK;
  logic          RESET;
  logic [DW-1:0] v_threshold;
  logic [DW-1:0] v_reset;
  logic [4:0]    decay_shift;
  logic [1:0]    mode;
  logic          ts_start;
  logic          ts_end;
  logic          w_valid;
  logic          w_ready;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_data;
  logic [NN-1:0] spike_out;
  logic          done;
  logic          busy;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  neuron_potential_array #(.NUM_NEURONS(NN), .DATA_W(DW), .IDX_W(IW)) dut (
    .CLK(CLK), .RESET(RESET), .v_threshold(v_threshold), .v_reset(v_reset),
    .decay_shift(decay_shift), .mode(mode), .ts_start(ts_start), .ts_end(ts_end),
    .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx), .w_data(w_data),
    .spike_out(spike_out), .done(done), .busy(busy), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] thr;
    logic [31:0] vres;
    logic [4:0]  shift;
    int          nb;
    logic [3:0]  i0;
    logic [31:0] d0;
    logic [3:0]  i1;
    logic [31:0] d1;
    logic [9:0]  spk;
    logic [3:0]  c0;
    logic [31:0] e0;
    logic [3:0]  c1;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input int idx, input logic [31:0] exp, input string nm);
    rd_idx = IW'(idx);
    #1;
    chk($sformatf("%s[%0d]", nm, idx), rd_data, exp);
  endtask

  // n counts edges since the edge that sampled ts_end; latency includes the ts_end cycle.
  task automatic wait_done(input int start, output int lat);
    int n;
    n = start;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    lat = (done === 1'b1) ? n + 1 : -1;
  endtask

  initial begin
    int lat;
    int seen;
    vec_t v;

    RESET = 1'b1; v_threshold = '0; v_reset = '0; decay_shift = '0; mode = '0;
    ts_start = 1'b0; ts_end = 1'b0; w_valid = 1'b0; w_idx = '0; w_data = '0; rd_idx = '0;

    // mode, thr, vres, shift, beats, idx0/data0, idx1/data1, spikes, check neuron/value x2
    tbl[0] = '{mode:2'd0, thr:32'd100, vres:32'd0, shift:5'd0, nb:2, i0:4'd3, d0:32'd60, i1:4'd3, d1:32'd60,
               spk:10'h008, c0:4'd3, e0:32'd20, c1:4'd5, e1:32'd0};
    tbl[1] = '{mode:2'd2, thr:32'd1000, vres:32'd0, shift:5'd0, nb:1, i0:4'd5, d0:32'd64, i1:4'd0, d1:32'd0,
               spk:10'h000, c0:4'd5, e0:32'd64, c1:4'd3, e1:32'd20};
    tbl[2] = '{mode:2'd0, thr:32'd1000, vres:32'd0, shift:5'd2, nb:0, i0:4'd0, d0:32'd0, i1:4'd0, d1:32'd0,
               spk:10'h000, c0:4'd5, e0:32'd48, c1:4'd3, e1:32'd15};
    tbl[3] = '{mode:2'd1, thr:32'd100, vres:32'hFFFFFFFB, shift:5'd0, nb:1, i0:4'd5, d0:32'd200, i1:4'd0, d1:32'd0,
               spk:10'h020, c0:4'd5, e0:32'hFFFFFFFB, c1:4'd3, e1:32'd15};
    tbl[4] = '{mode:2'd2, thr:32'h7FFFFFFF, vres:32'd0, shift:5'd0, nb:1, i0:4'd0, d0:32'h7FFFFFF0, i1:4'd0, d1:32'd0,
               spk:10'h000, c0:4'd0, e0:32'h7FFFFFF0, c1:4'd5, e1:32'hFFFFFFFB};
    tbl[5] = '{mode:2'd2, thr:32'h7FFFFFFF, vres:32'd0, shift:5'd0, nb:1, i0:4'd0, d0:32'h00000100, i1:4'd0, d1:32'd0,
               spk:10'h001, c0:4'd0, e0:32'h7FFFFFFF, c1:4'd3, e1:32'd15};
    tbl[6] = '{mode:2'd2, thr:32'h7FFFFFFF, vres:32'd0, shift:5'd0, nb:2, i0:4'd1, d0:32'h80000000, i1:4'd1, d1:32'h80000000,
               spk:10'h001, c0:4'd1, e0:32'h80000000, c1:4'd0, e1:32'h7FFFFFFF};
    tbl[7] = '{mode:2'd3, thr:32'h80000000, vres:32'd0, shift:5'd0, nb:0, i0:4'd0, d0:32'd0, i1:4'd0, d1:32'd0,
               spk:10'h3FF, c0:4'd1, e0:32'd0, c1:4'd5, e1:32'h7FFFFFFB};

    tick();
    tick();
    RESET = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wready", 32'(w_ready), 32'd0);
    chk("rst_spike", 32'(spike_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) rd_chk(i, 32'd0, "rst_pot");

    for (int k = 0; k < 8; k++) begin
      v = tbl[k];
      tick();
      mode = v.mode; v_threshold = v.thr; v_reset = v.vres; decay_shift = v.shift;
      ts_start = 1'b1;
      tick();
      ts_start = 1'b0;
      if (v.nb == 0) begin
        ts_end = 1'b1;
        tick();
      end else begin
        for (int b = 0; b < v.nb; b++) begin
          w_valid = 1'b1;
          w_idx   = (b == 0) ? v.i0 : v.i1;
          w_data  = (b == 0) ? v.d0 : v.d1;
          ts_end  = (b == v.nb - 1);
          tick();
        end
      end
      w_valid = 1'b0; ts_end = 1'b0;
      wait_done(0, lat);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(NN + 1));
      chk($sformatf("v%0d_spike", k), 32'(spike_out), 32'(v.spk));
      tick();
      chk($sformatf("v%0d_done_pulse", k), 32'(done), 32'd0);
      chk($sformatf("v%0d_busy_after", k), 32'(busy), 32'd0);
      rd_chk(int'(v.c0), v.e0, $sformatf("v%0d_pot", k));
      rd_chk(int'(v.c1), v.e1, $sformatf("v%0d_pot", k));
    end

    // Handshake edges, starting from all-zero potentials.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mode = 2'd0; v_threshold = 32'd100; v_reset = '0; decay_shift = '0;
    w_valid = 1'b1; w_idx = 4'd2; w_data = 32'd500;
    tick();
    chk("idle_wready", 32'(w_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    w_valid = 1'b0;
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
    chk("accum_wready", 32'(w_ready), 32'd1);
    w_valid = 1'b1; w_idx = 4'd12; w_data = 32'd999;
    tick();
    w_idx = 4'd2; w_data = 32'd50; ts_end = 1'b1;
    tick();
    w_valid = 1'b0; ts_end = 1'b0;
    tick();
    // A honoured restart here would relatch threshold 10 before neuron 2 is processed.
    mode = 2'd1; v_threshold = 32'd10; v_reset = 32'd7; ts_start = 1'b1;
    tick();
    ts_start = 1'b0; mode = 2'd0; v_threshold = 32'd100; v_reset = '0;
    wait_done(2, lat);
    chk("hs_latency", 32'(lat), 32'(NN + 1));
    chk("hs_spike", 32'(spike_out), 32'd0);
    tick();
    chk("hs_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) rd_chk(i, (i == 2) ? 32'd50 : 32'd0, "hs_pot");
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    chk("idle_ts_end_busy", 32'(busy), 32'd0);

    // Reset arriving four cycles after ts_end.
    mode = 2'd2; v_threshold = 32'h7FFFFFFF;
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
    w_valid = 1'b1; w_idx = 4'd4; w_data = 32'd77; ts_end = 1'b1;
    tick();
    w_valid = 1'b0; ts_end = 1'b0;
    wait_done(0, lat);
    chk("pre_rst_latency", 32'(lat), 32'(NN + 1));
    tick();
    rd_chk(4, 32'd77, "pre_rst_pot");
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
    w_valid = 1'b1; w_idx = 4'd6; w_data = 32'd33; ts_end = 1'b1;
    tick();
    w_valid = 1'b0; ts_end = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wready", 32'(w_ready), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1) seen = 1;
      tick();
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    chk("mid_rst_spike", 32'(spike_out), 32'd0);
    for (int i = 0; i < 16; i++) rd_chk(i, 32'd0, "mid_rst_pot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_potential_array.md
NEURON_POTENTIAL_ARRAY -- requirements
Module: neuron_potential_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, the number of neurons held.
REQ-002 SHALL have parameter DATA_W, default 32, the width of the signed two's-complement potential, weight and threshold.
REQ-003 SHALL have parameter IDX_W, default 4, the neuron index width, with 2^IDX_W >= NUM_NEURONS.
REQ-004 SHALL have port CLK  in  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port v_threshold  in  DATA_W  the spike threshold, sampled at ts_start.
REQ-007 SHALL have port v_reset  in  DATA_W  the post-spike potential for mode 1, sampled at ts_start.
REQ-008 SHALL have port decay_shift  in  5  the leak shift; 0 means no leak; sampled at ts_start.
REQ-009 SHALL have port mode  in  2  0=subtract-reset, 1=reset-to-value, 2=integrate-only, 3=same as 0; sampled at ts_start.
REQ-010 SHALL have port ts_start  in  1  a one-cycle pulse that opens a timestep.
REQ-011 SHALL have port ts_end  in  1  a one-cycle pulse that closes accumulation.
REQ-012 SHALL have ports w_valid  in  1, w_ready  out  1, w_idx  in  IDX_W, w_data  in  DATA_W, forming the weight-input handshake.
REQ-013 SHALL have port spike_out  out  NUM_NEURONS  the per-neuron spike vector, held until the next update.
REQ-014 SHALL have port done  out  1  a one-cycle pulse when spike_out is valid.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have ports rd_idx  in  IDX_W and rd_data  out  DATA_W, a combinational potential read; rd_data SHALL be 0 when rd_idx >= NUM_NEURONS.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM, UPDATE and DONE.
REQ-018 In IDLE, ts_start SHALL latch the config inputs, clear all per-neuron accumulators and move to ACCUM; ts_end in IDLE SHALL be ignored.
REQ-019 In ACCUM, w_ready SHALL be 1; in all other states it SHALL be 0.
REQ-020 A beat (w_valid and w_ready) SHALL perform acc[w_idx] = sat(acc[w_idx] + w_data).
REQ-021 A beat with w_idx >= NUM_NEURONS SHALL be accepted and discarded.
REQ-022 ts_end in ACCUM SHALL move the FSM to UPDATE; a beat in the same cycle SHALL still be accumulated.
REQ-023 ts_start outside IDLE SHALL be ignored.
REQ-024 UPDATE SHALL process exactly one neuron per cycle, indices 0..NUM_NEURONS-1 in order.
REQ-025 For each neuron, decayed SHALL be v when decay_shift is 0, else v - (v >>> decay_shift) (arithmetic shift).
REQ-026 sum SHALL be sat(decayed + acc), and spike SHALL be (sum >= v_threshold), compared as signed.
REQ-027 The new v SHALL be: mode 0/3: sat(sum - v_threshold) if spike, else sum; mode 1: v_reset if spike, else sum; mode 2: sum, with the spike still flagged.
REQ-028 sat() SHALL clamp to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-029 spike_out[i] SHALL update in the cycle neuron i is processed.
REQ-030 After the last neuron the FSM SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-031 If ts_end is sampled at cycle t, done SHALL be high at cycle t+NUM_NEURONS+1.
REQ-032 Potentials SHALL persist across timesteps; only accumulators are cleared at ts_start.

Reset
REQ-033 RESET SHALL force IDLE and set all potentials, accumulators, spike_out, done, busy and w_ready to 0.
REQ-034 RESET SHALL reset the latched config to: threshold 0, v_reset 0, decay_shift 0, mode 0.
REQ-035 RESET SHALL take priority over every other input in any state, including mid-UPDATE, with no done pulse.

Verification
REQ-036 Reset: assert RESET 2 cycles -> busy=0, w_ready=0, spike_out=0, done=0, rd_data=0 for every index.
REQ-037 Subtract reset: mode 0, threshold 100, shift 0, two beats of 60 to neuron 3, ts_end -> spike_out=0x008, neuron 3 = 20, done exactly 11 cycles after ts_end.
REQ-038 Leak and reset-to-value: neuron 5 = 64, shift 2, no beats -> neuron 5 = 48, no spike; then mode 1, v_reset -5, beat of 200 -> neuron 5 = -5, spike_out[5]=1.
REQ-039 Saturation: neuron 0 = 0x7FFFFFF0, mode 2, threshold 0x7FFFFFFF, beat 0x100 -> neuron 0 = 0x7FFFFFFF, spike_out[0]=1, potential unchanged by reset.
REQ-040 Handshake edges: beat with w_idx=12 -> no potential changes; beat coincident with ts_end counted; ts_start during UPDATE ignored; w_valid while in IDLE not accepted.
REQ-041 Reset mid-UPDATE: RESET asserted 4 cycles after ts_end -> IDLE next cycle, all potentials 0, no done pulse.
